// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_decode_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch with one outstanding imem request, a one-entry skid buffer
// for decode stalls, redirect flush/kill, and the IF/ID pipeline register.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        rst,
  fetch_decode_stage_if.master        imem,
  input  logic                        pc_src_e,
  input  logic [31:0]                 pc_target_e,
  input  logic                        stall_d,
  output logic                        valid_d,
  output logic [31:0]                 instr_d,
  output logic [31:0]                 pc_d,
  output logic [31:0]                 pc_plus4_d,
  output logic [6:0]                  Op_d,
  output logic [2:0]                  funct3_d,
  output logic [6:0]                  funct7_d,
  output logic [4:0]                  rs1_d,
  output logic [4:0]                  rs2_d,
  output logic [4:0]                  rd_d
);

  typedef enum logic [1:0] {StIssue, StWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic        kill_q, kill_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        load;
  logic [31:0] load_instr;
  logic        ifid_accept;
  logic [31:0] pc_f_plus4;

  // Redirect targets are word-aligned; the low bits are deliberately ignored.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^pc_target_e[1:0];

  assign ifid_accept = !stall_d || !ifid_valid_q;
  assign pc_f_plus4  = pc_f_q + 32'd4;

  assign imem.imem_req  = (state_q == StIssue);
  assign imem.imem_addr = pc_f_q;

  assign valid_d    = ifid_valid_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign Op_d       = ifid_instr_q[6:0];
  assign rd_d       = ifid_instr_q[11:7];
  assign funct3_d   = ifid_instr_q[14:12];
  assign rs1_d      = ifid_instr_q[19:15];
  assign rs2_d      = ifid_instr_q[24:20];
  assign funct7_d   = ifid_instr_q[31:25];

  // Next-state: fetch FSM, IF/ID load/bubble/hold, then redirect override.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    kill_d       = kill_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_instr_d = skid_instr_q;
    load         = 1'b0;
    load_instr   = NOP_INSTR;

    case (state_q)
      StIssue: state_d = StWait;
      StWait: begin
        if (imem.imem_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StIssue;
          end else if (ifid_accept) begin
            load       = 1'b1;
            load_instr = imem.imem_rdata;
            pc_f_d     = pc_f_plus4;
            state_d    = StIssue;
          end else begin
            // IF/ID is stalled with a live instruction: park the response.
            skid_instr_d = imem.imem_rdata;
            state_d      = StFull;
          end
        end
      end
      StFull: begin
        if (!stall_d) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          pc_f_d     = pc_f_plus4;
          state_d    = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase

    // pc_f still holds the PC of the loaded instruction in both load paths.
    if (load) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = load_instr;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_f_plus4;
    end else if (!stall_d) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end

    if (pc_src_e) begin
      pc_f_d       = {pc_target_e[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      case (state_q)
        // The request still leaves this cycle; its response must be dropped.
        StIssue: begin
          kill_d  = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (imem.imem_valid) begin
            kill_d  = 1'b0;
            state_d = StIssue;
          end else begin
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end
        default: begin
          kill_d  = 1'b0;
          state_d = StIssue;
        end
      endcase
    end
  end

  // State and pipeline registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIssue;
      pc_f_q       <= RESET_PC;
      kill_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0004;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      kill_q       <= kill_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a variable-latency imem model.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        stall_d;

  logic        valid_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [6:0]  Op_d, funct7_d;
  logic [2:0]  funct3_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic        valid_d2;
  logic [31:0] instr_d2, pc_d2, pc_plus4_d2;
  logic [6:0]  Op_d2, funct7_d2;
  logic [2:0]  funct3_d2;
  logic [4:0]  rs1_d2, rs2_d2, rd_d2;

  int unsigned n_checks;
  int unsigned n_fail;

  // Memory model controls.
  int unsigned lat;
  logic        ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  fetch_decode_stage_if bus ();
  fetch_decode_stage_if bus2 ();

  fetch_decode_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .stall_d     (stall_d),
    .valid_d     (valid_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .Op_d        (Op_d),
    .funct3_d    (funct3_d),
    .funct7_d    (funct7_d),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d)
  );

  fetch_decode_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .imem        (bus2),
    .pc_src_e    (1'b0),
    .pc_target_e (32'h0000_0000),
    .stall_d     (1'b0),
    .valid_d     (valid_d2),
    .instr_d     (instr_d2),
    .pc_d        (pc_d2),
    .pc_plus4_d  (pc_plus4_d2),
    .Op_d        (Op_d2),
    .funct3_d    (funct3_d2),
    .funct7_d    (funct7_d2),
    .rs1_d       (rs1_d2),
    .rs2_d       (rs2_d2),
    .rd_d        (rd_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // imem model for the main DUT: a request seen mid-cycle is answered `lat`
  // cycles later; responses for requests made before a reset are dropped.
  initial begin
    logic        pending;
    int unsigned cnt;
    logic [31:0] raddr;
    pending = 1'b0;
    cnt = 0;
    raddr = '0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_valid = 1'b0;
      if (!rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            pending = 1'b0;
            bus.imem_valid = 1'b1;
            bus.imem_rdata = (ovr_en && raddr == ovr_addr) ? ovr_data : raddr;
          end
        end
        if (bus.imem_req) begin
          pending = 1'b1;
          cnt = lat;
          raddr = bus.imem_addr;
        end
      end
    end
  end

  // imem model for the wrap-around DUT: latency 1, data = address.
  initial begin
    logic        pending;
    logic [31:0] raddr;
    pending = 1'b0;
    raddr = '0;
    bus2.imem_valid = 1'b0;
    bus2.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus2.imem_valid = 1'b0;
      if (!rst2) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          bus2.imem_valid = 1'b1;
          bus2.imem_rdata = raddr;
        end
        if (bus2.imem_req) begin
          pending = 1'b1;
          raddr = bus2.imem_addr;
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    rst2 = 1'b0;
    pc_src_e = 1'b0;
    pc_target_e = '0;
    stall_d = 1'b0;
    lat = 1;
    ovr_en = 1'b0;
    ovr_addr = '0;
    ovr_data = '0;

    // Reset state.
    tick(2);
    check_eq("rst_valid", {31'd0, valid_d}, 32'd0);
    check_eq("rst_instr", instr_d, 32'h0000_0013);
    check_eq("rst_pc_d", pc_d, 32'h0);
    check_eq("rst_pc4", pc_plus4_d, 32'h4);
    check_eq("rst_op", {25'd0, Op_d}, 32'h13);
    check_eq("rst_addr", bus.imem_addr, 32'h0);

    // Latency 1, data = address.
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    check_eq("t1_req0", {31'd0, bus.imem_req}, 32'd1);
    check_eq("t1_addr0", bus.imem_addr, 32'h0);
    tick();
    check_eq("t1_req_wait", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check_eq("t1_valid0", {31'd0, valid_d}, 32'd1);
    check_eq("t1_instr0", instr_d, 32'h0);
    check_eq("t1_pc0", pc_d, 32'h0);
    check_eq("t1_pc4_0", pc_plus4_d, 32'h4);
    check_eq("t1_addr4", bus.imem_addr, 32'h4);
    check_eq("t1_req4", {31'd0, bus.imem_req}, 32'd1);
    tick();
    check_eq("t1_bubble_valid", {31'd0, valid_d}, 32'd0);
    check_eq("t1_bubble_instr", instr_d, 32'h0000_0013);
    tick();
    check_eq("t1_valid4", {31'd0, valid_d}, 32'd1);
    check_eq("t1_instr4", instr_d, 32'h4);
    check_eq("t1_pc4", pc_d, 32'h4);
    check_eq("t1_op4", {25'd0, Op_d}, 32'h4);
    check_eq("t1_addr8", bus.imem_addr, 32'h8);

    // Asynchronous reset in the middle of a transaction.
    rst = 1'b0;
    #1;
    check_eq("arst_addr", bus.imem_addr, 32'h0);
    check_eq("arst_valid", {31'd0, valid_d}, 32'd0);
    check_eq("arst_instr", instr_d, 32'h0000_0013);
    check_eq("arst_pc4", pc_plus4_d, 32'h4);

    // Latency 3, R-type decode.
    lat = 3;
    ovr_en = 1'b1;
    ovr_addr = 32'h0;
    ovr_data = 32'h00A3_0333;
    tick(2);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    check_eq("t2_req", {31'd0, bus.imem_req}, 32'd1);
    tick();
    lat = 1;
    tick(2);
    check_eq("t2_not_yet", {31'd0, valid_d}, 32'd0);
    tick();
    check_eq("t2_valid", {31'd0, valid_d}, 32'd1);
    check_eq("t2_instr", instr_d, 32'h00A3_0333);
    check_eq("t2_funct7", {25'd0, funct7_d}, 32'h0);
    check_eq("t2_rs2", {27'd0, rs2_d}, 32'd10);
    check_eq("t2_rs1", {27'd0, rs1_d}, 32'd6);
    check_eq("t2_funct3", {29'd0, funct3_d}, 32'd0);
    check_eq("t2_rd", {27'd0, rd_d}, 32'd6);
    check_eq("t2_op", {25'd0, Op_d}, 32'h33);
    check_eq("t2_addr4", bus.imem_addr, 32'h4);

    // Stall with a response arriving: skid buffer.
    stall_d = 1'b1;
    tick();
    check_eq("t3_req_wait", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check_eq("t3_hold_valid", {31'd0, valid_d}, 32'd1);
    check_eq("t3_hold_instr", instr_d, 32'h00A3_0333);
    check_eq("t3_hold_pc", pc_d, 32'h0);
    check_eq("t3_full_noreq", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check_eq("t3_hold_instr2", instr_d, 32'h00A3_0333);
    check_eq("t3_full_noreq2", {31'd0, bus.imem_req}, 32'd0);
    stall_d = 1'b0;
    lat = 2;
    tick();
    check_eq("t3_skid_valid", {31'd0, valid_d}, 32'd1);
    check_eq("t3_skid_instr", instr_d, 32'h4);
    check_eq("t3_skid_pc", pc_d, 32'h4);
    check_eq("t3_skid_pc4", pc_plus4_d, 32'h8);
    check_eq("t3_next_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("t3_next_addr", bus.imem_addr, 32'h8);

    // Redirect while a request is outstanding.
    tick();
    pc_src_e = 1'b1;
    pc_target_e = 32'h0000_0102;
    tick();
    pc_src_e = 1'b0;
    check_eq("t4_valid", {31'd0, valid_d}, 32'd0);
    check_eq("t4_noreq", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check_eq("t4_discard", {31'd0, valid_d}, 32'd0);
    check_eq("t4_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("t4_addr", bus.imem_addr, 32'h100);
    tick();
    lat = 1;
    tick(2);
    check_eq("t4_new_valid", {31'd0, valid_d}, 32'd1);
    check_eq("t4_new_instr", instr_d, 32'h100);
    check_eq("t4_new_pc", pc_d, 32'h100);

    // Redirect while stalled with a valid IF/ID, request just issued.
    stall_d = 1'b1;
    pc_src_e = 1'b1;
    pc_target_e = 32'h0000_0200;
    tick();
    check_eq("t5_flush_valid", {31'd0, valid_d}, 32'd0);
    check_eq("t5_flush_instr", instr_d, 32'h0000_0013);
    pc_src_e = 1'b0;
    stall_d = 1'b0;
    tick();
    check_eq("t5_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("t5_addr", bus.imem_addr, 32'h200);
    check_eq("t5_valid", {31'd0, valid_d}, 32'd0);

    // PC wrap-around from RESET_PC = 0xFFFF_FFFC.
    @(posedge clk);
    #2 rst2 = 1'b1;
    tick();
    check_eq("t6_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    tick(2);
    check_eq("t6_valid", {31'd0, valid_d2}, 32'd1);
    check_eq("t6_pc_d", pc_d2, 32'hFFFF_FFFC);
    check_eq("t6_pc4", pc_plus4_d2, 32'h0);
    check_eq("t6_addr1", bus2.imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
